dog_line_filter: RTL and testbench
==================================

# dog_line_filter

One-dimensional Difference-of-Gaussian line filter that feeds the DoG write stage. It sits directly upstream of the RAM write stage and drives that stage's `dog_wr_valid_in` and `dog_wr_data_in`. The block takes raster pixels one line at a time, with 256 pixels per line, over 512 lines: 256 row-pass lines followed by 256 column-pass lines. For each line it emits exactly 262 result beats: 6 leading beats, which the write stage discards, followed by 256 centred results for x = 0..255.

## Interface
- `LINE_LEN`, default 256: pixels per line.
- `LINES`, default 512: lines per frame (row pass plus column pass).
- `SHIFT`, default 2: arithmetic right shift applied to the DoG sum before offset and saturation.
- `clk`  input  1: the single clock.
- `rst`  input  1: **synchronous, active-high** reset.
- `pix_valid_in`  input  1: input pixel valid.
- `pix_data_in`  input  8: input pixel, unsigned.
- `pix_ready_out`  output  1: pixel accepted when `pix_valid_in & pix_ready_out`.
- `dog_wr_valid_out`  output  1: result beat valid; connects to `dog_wr_valid_in` of the write stage.
- `dog_wr_data_out`  output  8: DoG result, offset-128, saturated.
- `line_done`  output  1: one-cycle pulse with the 262nd output beat of each line.
- `frame_done`  output  1: one-cycle pulse with `line_done` of line `LINES-1`.

## Operation
- Beat counter `k` runs 0..261 per line.
  - Beats 0..255 are accepted pixels.
  - Beats 256..261 are flush beats, generated internally on 6 consecutive cycles starting the cycle after beat 255 is accepted.
- `pix_ready_out` rules:
  - Low during flush.
  - High otherwise, outside reset.
  - `pix_valid_in` while ready is low is ignored.
- Window: a 10-entry shift register holding samples k-9..k.
  - The 7 oldest entries, samples k-9..k-3, form the tap window centred on pixel k-6.
  - Beat 6+x therefore yields the result for pixel x.
- Kernel: weights [-3,-2,3,4,3,-2,-3], which is binomial G1 [1,6,15,20,15,6,1]/64 minus box-like G2 [4,8,12,16,12,8,4]/64. The weights sum to 0.
- Arithmetic:
  - `diff` = Σ wᵢ·sᵢ, 13-bit signed, range ±2550.
  - `res` = `(diff >>> SHIFT) + 128`, using an arithmetic shift (floor).
  - Saturate `res` to 0..255.
- Line counter 0..`LINES-1`; it wraps to 0 after `frame_done`.
- A line may start immediately after the previous flush. Idle gaps between pixels are allowed; the counters hold during gaps.

## Timing
- Latency is 3 cycles from each beat (accept or flush cycle) to its `dog_wr_valid_out`. The pipeline stages are:
  1. Shift-register update.
  2. Registered products and partial sums.
  3. Final sum and saturation.
- Output valids preserve beat order and gaps. There is no backpressure from downstream.
- Reset values:
  - `pix_ready_out` = 0 while `rst` is high, and 1 on the first cycle after.
  - `dog_wr_valid_out` = 0, `dog_wr_data_out` = 0.
  - `line_done` = 0, `frame_done` = 0.
  - Beat counter, line counter and pipeline valids = 0.
- Reset mid-line or mid-flush: all in-flight beats are dropped and no partial valids emerge. The next accepted pixel is beat 0 of line 0.
- The last pixel accepted in the same cycle as flush start cannot occur, because ready is already low.

## Configuration
- `DOG_EDGE_REPLICATE_EN`
  - Defined: at beat 0 all 10 window entries load the incoming pixel; flush beats shift in a copy of pixel 255 (clamp padding).
  - Undefined: at beat 0 the window clears to 0 and the pixel shifts in; flush beats shift in 0 (zero padding).
- Beat counts and latency are identical in both modes.

## Structure
- Package `dog_pkg` holds:
  - `LINE_LEN_C` = 256, `FLUSH_BEATS` = 6, `TAPS` = 7, `WIN_DEPTH` = 10.
  - The signed weight constants `DOG_W[0:6]`.
  - `DIFF_W` = 13.
- Sub-module `dog_kernel7` implements the 2-stage MAC (stages 2 and 3): a 7×8-bit window in, 8-bit saturated result out, with valid pipelined alongside. The top level owns the counters, flush control, window and done pulses.

## Test plan
- **Constant line:** every pixel = 100, both configurations, all lines → each line gives 262 valids with data 128 (replicate mode throughout; zero mode for x = 3..252); `line_done` on the 262nd.
- **Impulse:** pixel 100 = 16, all others 0 → x = 97..103 outputs 116, 120, 140, 144, 140, 120, 116; all other x output 128.
- **Edge padding:** pixel 0 = 200, others 0 → x = 0 output 228 with `DOG_EDGE_REPLICATE_EN`, 255 without.
- **Handshake:** 256 back-to-back pixels → `pix_ready_out` low for exactly 6 cycles after the 256th accept; last valid 3 cycles after the final flush beat. Random `pix_valid_in` gaps → same data, same beat count.
- **Reset mid-line:** `rst` pulsed at pixel 130 → no valids for 3 cycles after; the next line produces 262 correct beats; the line counter restarts at 0.
- **Frame:** 512 lines → `frame_done` pulses exactly once, coincident with the 512th `line_done`; the line counter returns to 0.

Source files
------------

// File: rtl/dog_pkg.sv
// Shared constants, types, kernel weights and saturation helper for the DoG line filter.
package dog_pkg;

   localparam int unsigned PIX_W       = 8;
   localparam int unsigned LINE_LEN_C  = 256;
   localparam int unsigned FLUSH_BEATS = 6;
   localparam int unsigned TAPS        = 7;
   localparam int unsigned WIN_DEPTH   = 10;
   localparam int unsigned DIFF_W      = 13;
   localparam int unsigned WGT_W       = 4;

   // Binomial G1 minus box-like G2 (both /64), oldest sample first; weights sum to zero
   localparam logic signed [WGT_W-1:0] DOG_W [0:TAPS-1] = '{
      -4'sd3, -4'sd2, 4'sd3, 4'sd4, 4'sd3, -4'sd2, -4'sd3
   };

   typedef logic [TAPS-1:0][PIX_W-1:0] taps_t;

   typedef struct packed {
      logic last;
      logic frame;
   } beat_tag_t;

   typedef enum logic {
      S_PIX   = 1'b0,
      S_FLUSH = 1'b1
   } state_e;

   function automatic logic [PIX_W-1:0] sat_pix(input logic signed [DIFF_W-1:0] v);
      if (v[DIFF_W-1]) return '0;
      if (v > DIFF_W'(255)) return '1;
      return PIX_W'(v);
   endfunction

endpackage

// File: rtl/dog_kernel7.sv
// Two-stage 7-tap DoG multiply-accumulate with offset-128 saturation.
// Valid and beat tag are carried alongside the data.
module dog_kernel7
   import dog_pkg::*;
#(
   parameter int unsigned SHIFT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  beat_tag_t        tag_i,
   input  taps_t            taps_i,
   output logic             valid_o,
   output beat_tag_t        tag_o,
   output logic [PIX_W-1:0] data_o
);

   logic signed [DIFF_W-1:0] prod_c [TAPS];
   logic signed [DIFF_W-1:0] psum_lo_d, psum_hi_d, psum_lo_q, psum_hi_q;
   logic signed [DIFF_W-1:0] sum_c, res_c;
   logic                     v2_q, valid_q;
   beat_tag_t                tag2_q, tag_q;
   logic [PIX_W-1:0]         data_d, data_q;

   // Stage 2: weighted products folded into two partial sums
   always_comb begin
      for (int unsigned i = 0; i < TAPS; i++) begin
         prod_c[i] = DIFF_W'(DOG_W[i]) * $signed(DIFF_W'(taps_i[i]));
      end
   end

   assign psum_lo_d = prod_c[0] + prod_c[1] + prod_c[2] + prod_c[3];
   assign psum_hi_d = prod_c[4] + prod_c[5] + prod_c[6];

   // Stage 3: floor shift, re-centre on 128, clamp to pixel range
   always_comb begin
      sum_c  = psum_lo_q + psum_hi_q;
      res_c  = (sum_c >>> SHIFT) + DIFF_W'(128);
      data_d = sat_pix(res_c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v2_q      <= 1'b0;
         tag2_q    <= '0;
         psum_lo_q <= '0;
         psum_hi_q <= '0;
         valid_q   <= 1'b0;
         tag_q     <= '0;
         data_q    <= '0;
      end else begin
         v2_q    <= valid_i;
         tag2_q  <= valid_i ? tag_i : '0;
         valid_q <= v2_q;
         tag_q   <= tag2_q;
         if (valid_i) begin
            psum_lo_q <= psum_lo_d;
            psum_hi_q <= psum_hi_d;
         end
         if (v2_q) begin
            data_q <= data_d;
         end
      end
   end

   assign valid_o = valid_q;
   assign tag_o   = tag_q;
   assign data_o  = data_q;

endmodule

// File: rtl/dog_line_filter.sv
// 1-D DoG line filter: beat/line counters, flush control and 10-deep sample window feeding dog_kernel7.
// Define DOG_EDGE_REPLICATE_EN for clamp padding at line edges; default is zero padding.
module dog_line_filter
   import dog_pkg::*;
#(
   parameter int unsigned LINE_LEN = LINE_LEN_C,
   parameter int unsigned LINES    = 512,
   parameter int unsigned SHIFT    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_valid_in,
   input  logic [PIX_W-1:0] pix_data_in,
   output logic             pix_ready_out,
   output logic             dog_wr_valid_out,
   output logic [PIX_W-1:0] dog_wr_data_out,
   output logic             line_done,
   output logic             frame_done
);

   localparam int unsigned BEATS = LINE_LEN + FLUSH_BEATS;
   localparam int unsigned K_W   = $clog2(BEATS);
   localparam int unsigned L_W   = (LINES > 1) ? $clog2(LINES) : 1;

   state_e                          state_q, state_d;
   logic [K_W-1:0]                  k_q, k_d;
   logic [L_W-1:0]                  line_q, line_d;
   logic                            accept_c, beat_c, flush_c;
   beat_tag_t                       tag_c, tag1_q, tag_out;
   logic [WIN_DEPTH-1:0][PIX_W-1:0] win_q, win_d;
   logic [PIX_W-1:0]                fill_c;
   logic                            v1_q;
   taps_t                           taps_c;

   assign pix_ready_out = (state_q == S_PIX) & ~rst;
   assign accept_c      = pix_valid_in & pix_ready_out;

   // Beat sequencing: 256 accepted pixels then 6 self-timed flush beats
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      line_d  = line_q;
      beat_c  = 1'b0;
      flush_c = 1'b0;
      tag_c   = '0;
      case (state_q)
         S_PIX: begin
            if (accept_c) begin
               beat_c = 1'b1;
               k_d    = k_q + 1'b1;
               if (k_q == K_W'(LINE_LEN - 1)) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            beat_c  = 1'b1;
            flush_c = 1'b1;
            k_d     = k_q + 1'b1;
            if (k_q == K_W'(BEATS - 1)) begin
               k_d         = '0;
               state_d     = S_PIX;
               tag_c.last  = 1'b1;
               tag_c.frame = (line_q == L_W'(LINES - 1));
               line_d      = tag_c.frame ? '0 : line_q + 1'b1;
            end
         end
         default: state_d = S_PIX;
      endcase
   end

   // Window update; index 0 holds the newest sample
   always_comb begin
      win_d = win_q;
`ifdef DOG_EDGE_REPLICATE_EN
      fill_c = flush_c ? win_q[0] : pix_data_in;
`else
      fill_c = flush_c ? '0 : pix_data_in;
`endif
      if (beat_c) begin
         if (!flush_c && (k_q == '0)) begin
`ifdef DOG_EDGE_REPLICATE_EN
            win_d = {WIN_DEPTH{pix_data_in}};
`else
            win_d    = '0;
            win_d[0] = pix_data_in;
`endif
         end else begin
            win_d = {win_q[WIN_DEPTH-2:0], fill_c};
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < TAPS; i++) begin
         taps_c[i] = win_q[WIN_DEPTH-1-i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_PIX;
         k_q     <= '0;
         line_q  <= '0;
         win_q   <= '0;
         v1_q    <= 1'b0;
         tag1_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         line_q  <= line_d;
         win_q   <= win_d;
         v1_q    <= beat_c;
         tag1_q  <= tag_c;
      end
   end

   dog_kernel7 #(
      .SHIFT (SHIFT)
   ) u_kernel (
      .clk     (clk),
      .rst     (rst),
      .valid_i (v1_q),
      .tag_i   (tag1_q),
      .taps_i  (taps_c),
      .valid_o (dog_wr_valid_out),
      .tag_o   (tag_out),
      .data_o  (dog_wr_data_out)
   );

   assign line_done  = tag_out.last;
   assign frame_done = tag_out.frame;

endmodule

// File: tb/tb_dog_line_filter.sv
// Self-checking bench for dog_line_filter: vector table on filtered lines plus handshake/reset/frame sequences.
module tb_dog_line_filter;

   localparam int LINE_LEN = 256;
   localparam int LINES    = 8;
   localparam int BEATS    = LINE_LEN + 6;
`ifdef DOG_EDGE_REPLICATE_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pix_valid_in = 1'b0;
   logic [7:0] pix_data_in = 8'd0;
   logic       pix_ready_out, dog_wr_valid_out, line_done, frame_done;
   logic [7:0] dog_wr_data_out;

   dog_line_filter #(.LINE_LEN(LINE_LEN), .LINES(LINES), .SHIFT(2)) dut (
      .clk              (clk),
      .rst              (rst),
      .pix_valid_in     (pix_valid_in),
      .pix_data_in      (pix_data_in),
      .pix_ready_out    (pix_ready_out),
      .dog_wr_valid_out (dog_wr_valid_out),
      .dog_wr_data_out  (dog_wr_data_out),
      .line_done        (line_done),
      .frame_done       (frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int d; bit ld; bit fd; int c; } beat_t;
   beat_t cap[$];
   beat_t mon_b;
   int    stray = 0;

   always @(negedge clk) begin
      if (dog_wr_valid_out) begin
         mon_b.d  = int'(dog_wr_data_out);
         mon_b.ld = line_done;
         mon_b.fd = frame_done;
         mon_b.c  = cyc;
         cap.push_back(mon_b);
      end else if (line_done || frame_done) begin
         stray++;
      end
   end

   int n_chk = 0;
   int n_pass = 0;
   int first_acc, last_acc;
   int res [0:4][0:255];

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   function automatic int pix(input int pat, input int x);
      case (pat)
         0:       return 100;
         1:       return (x == 100) ? 16 : 0;
         2:       return (x == 0) ? 200 : 0;
         3:       return (x == 50) ? 1 : 0;
         default: return (x * 37 + 11) % 256;
      endcase
   endfunction

   function automatic int model(input int pat, input int x);
      int w[7];
      int acc, j, s, r;
      w = '{-3, -2, 3, 4, 3, -2, -3};
      acc = 0;
      for (int i = 0; i < 7; i++) begin
         j = x - 3 + i;
         if (j < 0)              s = REP ? pix(pat, 0) : 0;
         else if (j > LINE_LEN-1) s = REP ? pix(pat, LINE_LEN-1) : 0;
         else                    s = pix(pat, j);
         acc += w[i] * s;
      end
      r = (acc >>> 2) + 128;
      if (r < 0) r = 0;
      if (r > 255) r = 255;
      return r;
   endfunction

   // Feeds npx pixels; for a full line also holds junk valid through the flush and counts ready-low cycles.
   task automatic drive_line(input int pat, input int npx, input bit gaps, output int low_cnt);
      int t;
      low_cnt = 0;
      for (int x = 0; x < npx; x++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            pix_valid_in = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         pix_valid_in = 1'b1;
         pix_data_in  = 8'(pix(pat, x));
         t = 0;
         while (!pix_ready_out && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t >= 50) chk("ready_timeout", t, 0);
         if (x == 0) first_acc = cyc;
         last_acc = cyc;
         @(negedge clk);
      end
      if (npx == LINE_LEN) begin
         pix_valid_in = 1'b1;
         pix_data_in  = 8'hEE;
         while (!pix_ready_out && low_cnt < 20) begin
            @(negedge clk);
            low_cnt++;
         end
      end
      pix_valid_in = 1'b0;
   endtask

   task automatic wait_out(input int n);
      int t = 0;
      while (cap.size() < n && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) chk("output_timeout", cap.size(), n);
      repeat (4) @(negedge clk);
   endtask

   task automatic check_line(input string name, input int pat);
      int nld, ldi, nfd, mism;
      wait_out(BEATS);
      chk($sformatf("%s beats", name), cap.size(), BEATS);
      nld = 0; ldi = -1; nfd = 0; mism = 0;
      foreach (cap[i]) begin
         if (cap[i].ld) begin nld++; ldi = i; end
         if (cap[i].fd) nfd++;
      end
      chk($sformatf("%s line_done count", name), nld, 1);
      chk($sformatf("%s line_done beat", name), ldi, BEATS - 1);
      chk($sformatf("%s frame_done count", name), nfd, 0);
      if (cap.size() >= BEATS) begin
         chk($sformatf("%s first valid cycle", name), cap[0].c, first_acc + 3);
         chk($sformatf("%s last valid cycle", name), cap[BEATS-1].c, last_acc + 9);
         for (int x = 0; x < LINE_LEN; x++) begin
            if (cap[6+x].d != model(pat, x)) mism++;
            res[pat][x] = cap[6+x].d;
         end
         chk($sformatf("%s data mismatches", name), mism, 0);
      end
      cap.delete();
   endtask

   typedef struct { int pat; int x; int exp_z; int exp_r; } vec_t;
   vec_t vecs[$];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int low, exp, nld, nfd, bad_ld, fd_no_ld, mism, fdi0, fdi1;

      vecs.push_back('{0,   0, 178, 128});
      vecs.push_back('{0,   3, 128, 128});
      vecs.push_back('{0, 128, 128, 128});
      vecs.push_back('{0, 252, 128, 128});
      vecs.push_back('{0, 255, 178, 128});
      vecs.push_back('{1,  96, 128, 128});
      vecs.push_back('{1,  97, 116, 116});
      vecs.push_back('{1,  98, 120, 120});
      vecs.push_back('{1,  99, 140, 140});
      vecs.push_back('{1, 100, 144, 144});
      vecs.push_back('{1, 101, 140, 140});
      vecs.push_back('{1, 102, 120, 120});
      vecs.push_back('{1, 103, 116, 116});
      vecs.push_back('{1, 104, 128, 128});
      vecs.push_back('{2,   0, 255, 228});
      vecs.push_back('{2,   1, 255,  28});
      vecs.push_back('{2,   2,  28,   0});
      vecs.push_back('{2,   3,   0,   0});
      vecs.push_back('{2,   4, 128, 128});
      vecs.push_back('{3,  47, 127, 127});
      vecs.push_back('{3,  48, 127, 127});
      vecs.push_back('{3,  49, 128, 128});
      vecs.push_back('{3,  50, 129, 129});
      vecs.push_back('{3,  51, 128, 128});

      // reset state
      repeat (3) @(negedge clk);
      chk("reset ready", pix_ready_out, 0);
      chk("reset valid", dog_wr_valid_out, 0);
      chk("reset data", dog_wr_data_out, 0);
      chk("reset line_done", line_done, 0);
      chk("reset frame_done", frame_done, 0);
      rst = 1'b0;
      #1;
      chk("ready first cycle after reset", pix_ready_out, 1);

      // back-to-back line, then the pattern lines
      drive_line(0, LINE_LEN, 1'b0, low);
      chk("flush ready-low cycles", low, 6);
      check_line("const", 0);
      for (int p = 1; p <= 3; p++) begin
         drive_line(p, LINE_LEN, 1'b0, low);
         check_line($sformatf("pattern%0d", p), p);
      end
      drive_line(4, LINE_LEN, 1'b1, low);
      chk("gapped flush ready-low cycles", low, 6);
      check_line("ramp gapped", 4);
      drive_line(0, LINE_LEN, 1'b1, low);
      check_line("const gapped", 0);

      foreach (vecs[i]) begin
         exp = REP ? vecs[i].exp_r : vecs[i].exp_z;
         chk($sformatf("vec pat%0d x%0d", vecs[i].pat, vecs[i].x), res[vecs[i].pat][vecs[i].x], exp);
      end

      // reset in the middle of a line
      drive_line(4, 131, 1'b0, low);
      rst = 1'b1;
      @(posedge clk);
      #1;
      cap.delete();
      chk("ready during mid-line reset", pix_ready_out, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ready after mid-line reset", pix_ready_out, 1);
      repeat (5) @(negedge clk);
      chk("valids after mid-line reset", cap.size(), 0);
      drive_line(4, LINE_LEN, 1'b0, low);
      check_line("post-reset line", 4);

      // frame: 15 more back-to-back lines; frame_done on the 8th and 16th line since reset
      for (int n = 0; n < 15; n++) drive_line(0, LINE_LEN, 1'b0, low);
      wait_out(15 * BEATS);
      chk("frame total beats", cap.size(), 15 * BEATS);
      nld = 0; nfd = 0; bad_ld = 0; fd_no_ld = 0; mism = 0; fdi0 = -1; fdi1 = -1;
      foreach (cap[i]) begin
         if (cap[i].ld) begin
            nld++;
            if ((i % BEATS) != BEATS - 1) bad_ld++;
         end
         if (cap[i].fd) begin
            nfd++;
            if (!cap[i].ld) fd_no_ld++;
            if (fdi0 < 0) fdi0 = i; else fdi1 = i;
         end
         if ((i % BEATS) >= 6 && cap[i].d != model(0, (i % BEATS) - 6)) mism++;
      end
      chk("frame line_done count", nld, 15);
      chk("frame misplaced line_done", bad_ld, 0);
      chk("frame frame_done count", nfd, 2);
      chk("frame first frame_done beat", fdi0, 6 * BEATS + BEATS - 1);
      chk("frame second frame_done beat", fdi1, 14 * BEATS + BEATS - 1);
      chk("frame_done without line_done", fd_no_ld, 0);
      chk("frame data mismatches", mism, 0);
      cap.delete();

      chk("done pulses without valid", stray, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
